// File: rtl/seg_step_monitor.sv
// Passive monitor for a seven-segment bus: debounces each new pattern, decodes it
// back to a hex digit and classifies every accepted change as up/down step, jump or bad code.
module seg_step_monitor #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_seg,
    output logic [3:0] o_value,
    output logic       o_valid,
    output logic       o_step_up,
    output logic       o_step_down,
    output logic       o_jump,
    output logic       o_bad_code,
    output logic       o_dir,
    output logic [7:0] o_err_count
);

    // state    | meaning
    // ST_EMPTY | no valid digit accepted since reset (o_valid = 0)
    // ST_TRACK | o_value holds the last accepted digit; new digits are classified against it
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_TRACK = 1'b1;

    localparam int unsigned STABLE_CLAMP = (STABLE_CYCLES < 2)  ? 2  :
                                           (STABLE_CYCLES > 15) ? 15 : STABLE_CYCLES;
    localparam logic [3:0]  STABLE_CNT   = 4'(STABLE_CLAMP);

    logic [6:0] w_seg_in;
    logic       w_unused_dp;
    logic [6:0] r_seg_q;
    logic [3:0] r_stable_cnt;
    logic [6:0] r_last_pat;
    logic       r_last_vld;
    logic [0:0] r_state;
    logic [3:0] r_value;
    logic       r_dir;
    logic [7:0] r_err_count;
    logic       r_step_up;
    logic       r_step_down;
    logic       r_jump;
    logic       r_bad_code;

    logic       w_code_ok;
    logic [3:0] w_code;
    logic [3:0] w_value_p1;
    logic [3:0] w_value_m1;
    logic       w_accept;
    logic       w_is_up;
    logic       w_is_down;
    logic       w_err_evt;

    // The decimal point never takes part in decoding.
    assign w_seg_in    = SEG_ACTIVE_LOW ? ~i_seg[6:0] : i_seg[6:0];
    assign w_unused_dp = i_seg[7];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_seg_q      <= 7'h00;
            r_stable_cnt <= 4'd0;
        end else begin
            r_seg_q <= w_seg_in;
            if (w_seg_in != r_seg_q) begin
                r_stable_cnt <= 4'd1;
            end else if (r_stable_cnt != STABLE_CNT) begin
                r_stable_cnt <= r_stable_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        w_code_ok = 1'b1;
        w_code    = 4'h0;
        case (r_seg_q)
            7'h3F:   w_code = 4'h0;
            7'h06:   w_code = 4'h1;
            7'h5B:   w_code = 4'h2;
            7'h4F:   w_code = 4'h3;
            7'h66:   w_code = 4'h4;
            7'h6D:   w_code = 4'h5;
            7'h7D:   w_code = 4'h6;
            7'h07:   w_code = 4'h7;
            7'h7F:   w_code = 4'h8;
            7'h6F:   w_code = 4'h9;
            7'h77:   w_code = 4'hA;
            7'h7C:   w_code = 4'hB;
            7'h39:   w_code = 4'hC;
            7'h5E:   w_code = 4'hD;
            7'h79:   w_code = 4'hE;
            7'h71:   w_code = 4'hF;
            default: w_code_ok = 1'b0;
        endcase
    end

    // Comparing against the last accepted pattern (not the last digit) keeps a run
    // from being accepted twice, e.g. after a short glitch back to the same glyph.
    assign w_accept   = (r_stable_cnt == STABLE_CNT) &&
                        (!r_last_vld || (r_seg_q != r_last_pat));
    assign w_value_p1 = r_value + 4'd1;
    assign w_value_m1 = r_value - 4'd1;
    assign w_is_up    = (w_code == w_value_p1);
    assign w_is_down  = (w_code == w_value_m1);
    assign w_err_evt  = w_accept &&
                        (!w_code_ok || ((r_state == ST_TRACK) && !w_is_up && !w_is_down));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_EMPTY;
            r_last_pat  <= 7'h00;
            r_last_vld  <= 1'b0;
            r_value     <= 4'h0;
            r_dir       <= 1'b1;
            r_err_count <= 8'h00;
            r_step_up   <= 1'b0;
            r_step_down <= 1'b0;
            r_jump      <= 1'b0;
            r_bad_code  <= 1'b0;
        end else begin
            r_step_up   <= 1'b0;
            r_step_down <= 1'b0;
            r_jump      <= 1'b0;
            r_bad_code  <= 1'b0;

            if (w_accept) begin
                r_last_pat <= r_seg_q;
                r_last_vld <= 1'b1;
                if (!w_code_ok) begin
                    r_bad_code <= 1'b1;
                end else if (r_state == ST_EMPTY) begin
                    r_value <= w_code;
                    r_state <= ST_TRACK;
                end else begin
                    r_value <= w_code;
                    if (w_is_up) begin
                        r_step_up <= 1'b1;
                        r_dir     <= 1'b1;
                    end else if (w_is_down) begin
                        r_step_down <= 1'b1;
                        r_dir       <= 1'b0;
                    end else begin
                        r_jump <= 1'b1;
                    end
                end
            end

            if (w_err_evt && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign o_value     = r_value;
    assign o_valid     = (r_state == ST_TRACK);
    assign o_step_up   = r_step_up;
    assign o_step_down = r_step_down;
    assign o_jump      = r_jump;
    assign o_bad_code  = r_bad_code;
    assign o_dir       = r_dir;
    assign o_err_count = r_err_count;

endmodule

// File: tb/tb_seg_step_monitor.sv
// Bench for seg_step_monitor: directed table, hand-written corner sequences and random
// stimulus, all checked every cycle against a sample-history reference model.
module tb_seg_step_monitor;

    localparam int STABLE = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] seg_h;
    logic [7:0] seg_l;

    logic [3:0] value_h, value_l;
    logic       valid_h, valid_l, up_h, up_l, dn_h, dn_l;
    logic       jump_h, jump_l, bad_h, bad_l, dir_h, dir_l;
    logic [7:0] err_h, err_l;

    always #5 clk = ~clk;
    assign seg_l = ~seg_h;

    seg_step_monitor #(.STABLE_CYCLES(STABLE), .SEG_ACTIVE_LOW(1'b0)) dut_h (
        .i_clk(clk), .i_rst(rst), .i_seg(seg_h),
        .o_value(value_h), .o_valid(valid_h), .o_step_up(up_h), .o_step_down(dn_h),
        .o_jump(jump_h), .o_bad_code(bad_h), .o_dir(dir_h), .o_err_count(err_h)
    );

    seg_step_monitor #(.STABLE_CYCLES(STABLE), .SEG_ACTIVE_LOW(1'b1)) dut_l (
        .i_clk(clk), .i_rst(rst), .i_seg(seg_l),
        .o_value(value_l), .o_valid(valid_l), .o_step_up(up_l), .o_step_down(dn_l),
        .o_jump(jump_l), .o_bad_code(bad_l), .o_dir(dir_l), .o_err_count(err_l)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: keeps the raw samples since reset and applies the rules directly
    logic [6:0] glyph [16];
    logic [6:0] m_hist [$];
    bit         m_last_vld;
    logic [6:0] m_last;
    int         m_value, m_err;
    bit         m_valid, m_dir, m_up, m_dn, m_jump, m_bad;

    int acc_up, acc_dn, acc_jump, acc_bad;

    typedef struct {
        logic [7:0] seg;
        int         cycles;
        int         value;
        int         valid;
        int         dir;
        int         err;
        int         n_up;
        int         n_dn;
        int         n_jump;
        int         n_bad;
    } vec_t;
    vec_t vecs [$];

    function automatic int decode(input logic [6:0] p);
        for (int k = 0; k < 16; k++) if (glyph[k] == p) return k;
        return -1;
    endfunction

    task automatic model_reset();
        m_hist.delete();
        m_last_vld = 0; m_last = '0;
        m_value = 0; m_err = 0; m_valid = 0; m_dir = 1;
        m_up = 0; m_dn = 0; m_jump = 0; m_bad = 0;
    endtask

    task automatic model_edge();
        bit         same;
        logic [6:0] pat;
        int         c, d;
        m_up = 0; m_dn = 0; m_jump = 0; m_bad = 0;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_hist.size() == STABLE) begin
            pat  = m_hist[0];
            same = 1;
            foreach (m_hist[k]) if (m_hist[k] != pat) same = 0;
            if (same && (!m_last_vld || pat != m_last)) begin
                m_last_vld = 1;
                m_last     = pat;
                c          = decode(pat);
                if (c < 0) begin
                    m_bad = 1;
                    m_err = (m_err < 255) ? m_err + 1 : 255;
                end else if (!m_valid) begin
                    m_valid = 1;
                    m_value = c;
                end else begin
                    d = (c - m_value + 16) % 16;
                    if (d == 1) begin
                        m_up = 1; m_dir = 1;
                    end else if (d == 15) begin
                        m_dn = 1; m_dir = 0;
                    end else begin
                        m_jump = 1;
                        m_err  = (m_err < 255) ? m_err + 1 : 255;
                    end
                    m_value = c;
                end
            end
        end
        m_hist.push_back(seg_h[6:0]);
        if (m_hist.size() > STABLE) void'(m_hist.pop_front());
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [18:0] e, a_h, a_l;
        e   = {4'(m_value), m_valid, m_up, m_dn, m_jump, m_bad, m_dir, 8'(m_err)};
        a_h = {value_h, valid_h, up_h, dn_h, jump_h, bad_h, dir_h, err_h};
        a_l = {value_l, valid_l, up_l, dn_l, jump_l, bad_l, dir_l, err_l};
        check("model_active_high", int'(a_h), int'(e));
        check("model_active_low", int'(a_l), int'(e));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
        acc_up   += int'(up_h);
        acc_dn   += int'(dn_h);
        acc_jump += int'(jump_h);
        acc_bad  += int'(bad_h);
    endtask

    task automatic clear_acc();
        acc_up = 0; acc_dn = 0; acc_jump = 0; acc_bad = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_value"}, int'(value_h), 0);
        check({tag, "_valid"}, int'(valid_h), 0);
        check({tag, "_dir"}, int'(dir_h), 1);
        check({tag, "_err"}, int'(err_h), 0);
        check({tag, "_pulses"}, int'({up_h, dn_h, jump_h, bad_h}), 0);
    endtask

    task automatic add(input logic [7:0] s, input int cyc, input int v, input int vl,
                       input int dr, input int er, input int nu, input int nd,
                       input int nj, input int nb);
        vec_t t;
        t.seg = s; t.cycles = cyc; t.value = v; t.valid = vl; t.dir = dr; t.err = er;
        t.n_up = nu; t.n_dn = nd; t.n_jump = nj; t.n_bad = nb;
        vecs.push_back(t);
    endtask

    initial begin
        glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        model_reset();
        clear_acc();

        //   seg    cyc val valid dir err up dn jmp bad
        add(8'h3F, 10, 0,  1,  1,  0,  0, 0, 0, 0);
        add(8'h06, 10, 1,  1,  1,  0,  1, 0, 0, 0);
        add(8'h5B, 10, 2,  1,  1,  0,  1, 0, 0, 0);
        add(8'h06, 10, 1,  1,  0,  0,  0, 1, 0, 0);
        add(8'h3F, 10, 0,  1,  0,  0,  0, 1, 0, 0);
        add(8'h71, 10, 15, 1,  0,  0,  0, 1, 0, 0);
        add(8'h3F, 10, 0,  1,  1,  0,  1, 0, 0, 0);
        add(8'h06,  2, 0,  1,  1,  0,  0, 0, 0, 0);
        add(8'h3F, 10, 0,  1,  1,  0,  0, 0, 0, 0);
        add(8'h00,  8, 0,  1,  1,  1,  0, 0, 0, 1);
        add(8'h6D, 10, 5,  1,  1,  2,  0, 0, 1, 0);
        add(8'h00, 10, 5,  1,  1,  3,  0, 0, 0, 1);
        add(8'hFD, 10, 6,  1,  1,  3,  1, 0, 0, 0);
        add(8'h7F, 10, 8,  1,  1,  4,  0, 0, 1, 0);
        add(8'h00, 10, 8,  1,  1,  5,  0, 0, 0, 1);
        add(8'h7F, 10, 8,  1,  1,  6,  0, 0, 1, 0);
        add(8'h08,  3, 8,  1,  1,  6,  0, 0, 0, 0);
        add(8'h71, 10, 15, 1,  1,  7,  0, 0, 1, 0);

        // first digit: reset two cycles while 0x3F is presented, accept on the 5th edge
        rst   = 1'b1;
        seg_h = 8'h3F;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        for (int e = 0; e <= STABLE; e++) begin
            tick();
            check($sformatf("latency_valid_e%0d", e), int'(valid_h), (e == STABLE) ? 1 : 0);
        end
        check("first_value", int'(value_h), 0);

        foreach (vecs[i]) begin
            seg_h = vecs[i].seg;
            clear_acc();
            repeat (vecs[i].cycles) tick();
            check($sformatf("vec%0d_value", i), int'(value_h), vecs[i].value);
            check($sformatf("vec%0d_valid", i), int'(valid_h), vecs[i].valid);
            check($sformatf("vec%0d_dir", i), int'(dir_h), vecs[i].dir);
            check($sformatf("vec%0d_err", i), int'(err_h), vecs[i].err);
            check($sformatf("vec%0d_pulses", i),
                  (acc_up << 12) | (acc_dn << 8) | (acc_jump << 4) | acc_bad,
                  (vecs[i].n_up << 12) | (vecs[i].n_dn << 8) | (vecs[i].n_jump << 4) | vecs[i].n_bad);
        end

        // reset in the middle of a hold discards the partial count
        seg_h = 8'h5B;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst = 1'b0;
        for (int e = 0; e <= STABLE; e++) begin
            tick();
            check($sformatf("midrst_valid_e%0d", e), int'(valid_h), (e == STABLE) ? 1 : 0);
        end
        check("midrst_value", int'(value_h), 2);

        // 300 alternating jumps saturate the error counter
        clear_acc();
        for (int j = 0; j < 300; j++) begin
            seg_h = (j % 2 == 0) ? 8'h66 : 8'h3F;
            repeat (5) tick();
        end
        check("sat_jumps", acc_jump, 300);
        check("sat_err", int'(err_h), 255);
        clear_acc();
        seg_h = 8'h00;
        repeat (6) tick();
        check("sat_bad_pulse", acc_bad, 1);
        check("sat_err_hold", int'(err_h), 255);

        // random patterns, hold lengths and occasional resets
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int r = 0; r < 400; r++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 4)
                seg_h = {1'($urandom_range(0, 1)), glyph[(m_value + ((sel < 2) ? 1 : 15)) % 16]};
            else if (sel < 7)
                seg_h = {1'($urandom_range(0, 1)), glyph[$urandom_range(0, 15)]};
            else
                seg_h = 8'($urandom);
            rst = ($urandom_range(0, 39) == 0);
            tick();
            rst = 1'b0;
            repeat ($urandom_range(0, 6)) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_step_monitor.md
# seg_step_monitor

Receive-side companion to the up/down counter's seven-segment output. It samples the 8-bit segment bus, waits for each new pattern to be stable, and decodes the pattern back into a hex nibble. It then classifies every accepted change as an up step, a down step, an illegal jump or an invalid code. It sits on the display bus as a passive monitor for self-check on the board and in simulation. It never drives the bus.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples required before a pattern is accepted. Legal range is 2..15.
- SEG_ACTIVE_LOW, 0: if 1, the block inverts `seg` before decoding (common-anode display).
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- seg  in  8  segment bus `{dp,g,f,e,d,c,b,a}`; after the optional inversion, 1 means the segment is lit.
- value  out  4  last accepted valid digit.
- valid  out  1  high once any valid digit has been accepted.
- step_up  out  1  one-cycle pulse: accepted digit equals previous + 1 (mod 16).
- step_down  out  1  one-cycle pulse: accepted digit equals previous − 1 (mod 16).
- jump  out  1  one-cycle pulse: accepted valid digit is neither ±1 from the previous digit.
- bad_code  out  1  one-cycle pulse: accepted pattern is not a legal glyph.
- dir  out  1  direction of the last step (1 = up).
- err_count  out  8  saturating count of jump and bad_code events.

## Operation
- **Input register:** `seg` is registered into `seg_q`. The dp bit is ignored everywhere, so only `seg_q[6:0]` is used.
- **Glyph table (gfedcba, lit = 1):**
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
  - Any other pattern is an invalid code.
- **Stability counter:**
  - The counter increments while `seg_q[6:0]` is unchanged from the previous cycle and saturates at STABLE_CYCLES.
  - Any change reloads the counter to 1.
- **Acceptance event:** the counter reaches STABLE_CYCLES AND `seg_q[6:0]` differs from the last accepted pattern. A pattern is accepted at most once per stable run.
- **State machine** (two states):
  - EMPTY, with `valid`=0:
    - Valid code: load `value`, set `valid`, go to TRACK, no pulse.
    - Invalid code: `bad_code` pulse, `err_count`+1, stay in EMPTY.
  - TRACK:
    - Valid code c with previous p:
      - c = p+1 mod 16 → `step_up`, `dir`=1.
      - c = p−1 mod 16 → `step_down`, `dir`=0.
      - otherwise → `jump`, `err_count`+1, `dir` unchanged.
      - In all three cases `value` ← c.
    - Invalid code: `bad_code`, `err_count`+1. `value` and `valid` are unchanged.
  - The last-accepted pattern register is updated on every acceptance, including invalid codes. A return to the same invalid pattern is therefore not re-flagged, but a later valid digit is still compared against `value`.
- **Pulses:** at most one of `step_up`/`step_down`/`jump`/`bad_code` is high in any cycle.
- **Error counter:** `err_count` saturates at 255 and never wraps.
- **Counter reset:** when the counter is reset to 0 from any digit other than 1 or F, the monitor reports a jump. This is intended.

## Timing
- **Reset values:** after an edge with `rst`=1:
  - `value`=0, `valid`=0, `dir`=1, `err_count`=0, all pulses 0.
  - Stability counter=0, `seg_q`=0, last-accepted pattern cleared (no pattern), state EMPTY.
- **rst priority:** `rst` overrides everything in the same edge. Asserting it mid-run discards the partial stability count.
- **Latency:** a new pattern presented from edge E0 onward is captured into `seg_q` at E0. Outputs update at edge E0+STABLE_CYCLES. With the default, that is the 5th rising edge after the change.
- **Pulse width:** pulses are exactly one cycle and registered.
- **Glitches:** a pattern held for fewer than STABLE_CYCLES samples produces no event, and the prior run is not re-accepted afterwards.

## Test plan
1. **First digit.** Apply `rst` 2 cycles, then hold `seg`=0x3F → at E0+4, `valid`=1 and `value`=0; no pulses; `err_count`=0.
2. **Up steps.** Hold 0x3F→0x06→0x5B, 10 cycles each → two `step_up` pulses, `value`=2, `dir`=1, `err_count`=0.
3. **Wrap both ways.** From 0: hold 0x71 → `step_down`, `value`=F, `dir`=0. Then hold 0x3F → `step_up`, `value`=0, `dir`=1.
4. **Glitch.** Hold 0x3F, insert 0x06 for 2 cycles, return to 0x3F → no pulses, `value` stays 0.
5. **Errors.**
   - Hold 0x00 for 8 cycles → one `bad_code` pulse, `err_count`=1, `value` unchanged.
   - Then hold 0x6D (5) from `value` 0 → `jump`, `value`=5, `err_count`=2.
   - Drive 300 alternating jumps → `err_count` holds at 255.
6. **Reset and polarity.**
   - Assert `rst` for 1 cycle during a hold → every output at its reset value on the next edge, and the hold in progress is not accepted.
   - Rerun scenario 2 with SEG_ACTIVE_LOW=1 and inverted patterns (0xC0, 0xF9, 0xA4) → identical response.
